// File: rtl/jh_pkg.sv
// Shared types and constants for the JH message controller.
package jh_pkg;

  localparam int BLK_W       = 512;
  localparam int WORD_W      = 64;
  localparam int LEN_FIELD_W = 128;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_PADBLK = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Valid-byte count of a last word; anything above 8 means a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
    if (b > 4'd8) begin
      return 4'd8;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/jh_pad_mask.sv
// Keep-mask and '1'-bit placement for the last data block of a message.
module jh_pad_mask
  import jh_pkg::*;
(
  input  logic [3:0]       in_bytes,
  input  logic [2:0]       wcnt,
  input  logic             non_empty,
  output logic [BLK_W-1:0] keep_mask,
  output logic [BLK_W-1:0] one_bit,
  output logic             one_set
);

  logic [9:0] kept_s;

  // Bits kept from the top of the block, then the pad bit right after them
  always_comb begin
    kept_s    = {1'b0, wcnt, 6'd0} + {3'd0, clamp_bytes(in_bytes), 3'd0};
    keep_mask = ~({BLK_W{1'b1}} >> kept_s);
    one_set   = non_empty && (kept_s < 10'd512);
    if (one_set) begin
      one_bit = {1'b1, {(BLK_W-1){1'b0}}} >> kept_s;
    end else begin
      one_bit = {BLK_W{1'b0}};
    end
  end

endmodule

// File: rtl/jh_msg_ctrl.sv
// JH message controller: block assembly, padding and core sequencing.
module jh_msg_ctrl
  import jh_pkg::*;
#(
  parameter int OUT_BITS = 256,
  parameter int LEN_BITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_data,
  input  logic                in_last,
  input  logic [3:0]          in_bytes,
  output logic                core_en,
  output logic                core_init,
  output logic [511:0]        core_data,
  input  logic                core_fin,
  input  logic [511:0]        core_odata,
  output logic [OUT_BITS-1:0] digest,
  output logic                digest_valid,
  output logic                busy
);

  state_e              state_r, state_nxt_s;
  logic                hs_s, empty_msg_s, non_empty_s, pad_one_s, one_set_s;
  logic [2:0]          wcnt_r;
  logic [LEN_BITS-1:0] len_r, len_nxt_s;
  logic [LEN_BITS:0]   len_sum_s, len_inc_s;
  logic [BLK_W-1:0]    blk_r, blk_word_s, blk_last_s, pad_blk_s, keep_mask_s, one_bit_s;
  logic                first_blk_r, pad_pending_r, final_r, one_in_pad_r;
  logic                in_ready_r, core_en_r, core_init_r, digest_valid_r, busy_r;
  logic [OUT_BITS-1:0] digest_r;
  logic                odata_unused_s;

  assign odata_unused_s = ^core_odata;

  jh_pad_mask u_pad_mask (
    .in_bytes (in_bytes),
    .wcnt     (wcnt_r),
    .non_empty(non_empty_s),
    .keep_mask(keep_mask_s),
    .one_bit  (one_bit_s),
    .one_set  (one_set_s)
  );

  // Next-state decode
  always_comb begin
    hs_s        = in_valid && in_ready_r;
    empty_msg_s = (state_r == S_IDLE) && (in_bytes == 4'd0);
    non_empty_s = !empty_msg_s;
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (hs_s && in_last && empty_msg_s) begin
          state_nxt_s = S_PADBLK;
        end else if (hs_s && in_last) begin
          state_nxt_s = S_ISSUE;
        end else if (hs_s) begin
          state_nxt_s = S_FILL;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (hs_s && (in_last || (wcnt_r == 3'd7))) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_FILL;
        end
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (core_fin && pad_pending_r) begin
          state_nxt_s = S_PADBLK;
        end else if (core_fin && final_r) begin
          state_nxt_s = S_DONE;
        end else if (core_fin) begin
          state_nxt_s = S_FILL;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_PADBLK: state_nxt_s = S_ISSUE;
      S_DONE:   state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Word placement, last-word masking, length update and pad block image
  always_comb begin
    blk_word_s = blk_r;
    blk_word_s[{~wcnt_r, 6'd0} +: WORD_W] = in_data;
    blk_last_s = (blk_word_s & keep_mask_s) | one_bit_s;
    len_inc_s  = '0;
    if (in_last) begin
      len_inc_s[6:0] = {clamp_bytes(in_bytes), 3'd0};
    end else begin
      len_inc_s[6:0] = 7'd64;
    end
    len_sum_s = {1'b0, len_r} + len_inc_s;
    if (len_sum_s[LEN_BITS]) begin
      len_nxt_s = '1;
    end else begin
      len_nxt_s = len_sum_s[LEN_BITS-1:0];
    end
    // An empty message reaches the pad block straight from IDLE
    pad_one_s = (state_r == S_IDLE) ? 1'b1 : one_in_pad_r;
    pad_blk_s = '0;
    pad_blk_s[BLK_W-1 -: 8] = pad_one_s ? PAD_BYTE : 8'h00;
    pad_blk_s[LEN_FIELD_W-1:0] = LEN_FIELD_W'(len_r);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Block buffer, counters and per-message flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_r         <= '0;
      wcnt_r        <= 3'd0;
      len_r         <= '0;
      first_blk_r   <= 1'b0;
      pad_pending_r <= 1'b0;
      final_r       <= 1'b0;
      one_in_pad_r  <= 1'b0;
      digest_r      <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_FILL: begin
          if (hs_s) begin
            len_r  <= len_nxt_s;
            wcnt_r <= wcnt_r + 3'd1;
            if (state_r == S_IDLE) begin
              first_blk_r <= 1'b1;
            end
            if (in_last && empty_msg_s) begin
              blk_r <= pad_blk_s;
            end else if (in_last) begin
              blk_r         <= blk_last_s;
              pad_pending_r <= 1'b1;
              one_in_pad_r  <= !one_set_s;
            end else begin
              blk_r <= blk_word_s;
            end
          end
        end
        S_ISSUE: first_blk_r <= 1'b0;
        S_WAIT: begin
          if (core_fin && pad_pending_r) begin
            blk_r <= pad_blk_s;
          end else if (core_fin && final_r) begin
            digest_r <= core_odata[OUT_BITS-1:0];
          end else if (core_fin) begin
            blk_r  <= '0;
            wcnt_r <= 3'd0;
          end
        end
        S_PADBLK: begin
          final_r       <= 1'b1;
          pad_pending_r <= 1'b0;
        end
        S_DONE: begin
          blk_r         <= '0;
          wcnt_r        <= 3'd0;
          len_r         <= '0;
          final_r       <= 1'b0;
          one_in_pad_r  <= 1'b0;
          pad_pending_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r     <= 1'b0;
      core_en_r      <= 1'b0;
      core_init_r    <= 1'b0;
      digest_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      in_ready_r     <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_FILL);
      core_en_r      <= (state_nxt_s == S_ISSUE);
      core_init_r    <= (state_nxt_s == S_ISSUE) && (first_blk_r || (state_r == S_IDLE));
      digest_valid_r <= (state_nxt_s == S_DONE);
      busy_r         <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
    end
  end

  assign in_ready     = in_ready_r;
  assign core_en      = core_en_r;
  assign core_init    = core_init_r;
  assign core_data    = blk_r;
  assign digest       = digest_r;
  assign digest_valid = digest_valid_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_jh_msg_ctrl.sv
// Scoreboard bench for jh_msg_ctrl with a delayed-fin core stub.
module tb_jh_msg_ctrl;

  localparam int OUT_BITS = 256;

  logic                clk;
  logic                rst_n;
  logic                in_valid, in_ready, in_last;
  logic [63:0]         in_data;
  logic [3:0]          in_bytes;
  logic                core_en, core_init, core_fin;
  logic [511:0]        core_data, core_odata;
  logic [OUT_BITS-1:0] digest;
  logic                digest_valid, busy;

  jh_msg_ctrl #(.OUT_BITS(OUT_BITS), .LEN_BITS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .core_en(core_en), .core_init(core_init), .core_data(core_data),
    .core_fin(core_fin), .core_odata(core_odata),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [511:0]        exp_blk_q[$];
  logic                exp_init_q[$];
  logic [OUT_BITS-1:0] exp_dig_q[$];
  logic [7:0]          msg [0:255];

  int           fin_delay = 3;
  int           cyc = 0, fin_cyc = 0, cnt = 0, dv_cnt = 0, dv_start = 0;
  logic         pending = 1'b0, stab_bad = 1'b0;
  logic [511:0] cur_blk;

  function automatic logic [511:0] stub_fn(input logic [511:0] b);
    return b ^ {b[255:0], b[511:256]} ^ {8{64'h0123456789abcdef}};
  endfunction

  // Reference JH padding over the byte stream, split into expected blocks
  task automatic push_expected(input int n);
    logic [7:0]   pad [0:319];
    logic [63:0]  bitlen;
    logic [511:0] blk, od;
    int total;
    total = n + 64 + ((64 - (n % 64)) % 64);
    for (int i = 0; i < 320; i++) pad[i] = 8'h00;
    for (int i = 0; i < n; i++) pad[i] = msg[i];
    pad[n] = 8'h80;
    bitlen = 64'(n) * 64'd8;
    for (int i = 0; i < 8; i++) pad[total-1-i] = bitlen[8*i +: 8];
    blk = '0;
    for (int k = 0; k < total / 64; k++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*k+j];
      exp_blk_q.push_back(blk);
      exp_init_q.push_back(k == 0);
    end
    od = stub_fn(blk);
    exp_dig_q.push_back(od[OUT_BITS-1:0]);
  endtask

  task automatic send_msg(input int n);
    int words;
    logic [63:0] d;
    bit got;
    push_expected(n);
    dv_start = dv_cnt;
    words = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < words; w++) begin
      for (int b = 0; b < 8; b++) d[63-8*b -: 8] = (8*w + b < n) ? msg[8*w+b] : 8'hEE;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == words - 1);
      in_bytes = (w == words - 1) ? ((n == 0) ? 4'd0 : 4'(n - 8*(words-1))) : 4'd8;
      got = 1'b0;
      for (int t = 0; t < 500 && !got; t++) begin
        @(negedge clk);
        got = in_ready;
      end
      if (!got) begin
        chk("hs_timeout", 512'(got), 512'(1'b1));
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      seen = (dv_cnt != dv_start);
    end
    if (!seen) chk("dv_timeout", 512'(seen), 512'(1'b1));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 512'(in_ready), 512'(1'b0));
    chk("rst_en",    512'(core_en), 512'(1'b0));
    chk("rst_init",  512'(core_init), 512'(1'b0));
    chk("rst_dv",    512'(digest_valid), 512'(1'b0));
    chk("rst_busy",  512'(busy), 512'(1'b0));
    chk("rst_data",  core_data, 512'd0);
    chk("rst_dig",   512'(digest), 512'd0);
  endtask

  // Core stub and output monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (core_fin) core_fin = 1'b0;
      if (pending) begin
        if (core_data !== cur_blk || in_ready !== 1'b0 || core_en !== 1'b0) stab_bad = 1'b1;
        cnt--;
        if (cnt <= 0) begin
          core_fin   = 1'b1;
          core_odata = stub_fn(core_data);
          pending    = 1'b0;
          fin_cyc    = cyc;
          chk("hold", 512'(stab_bad), 512'(1'b0));
        end
      end
      if (core_en) begin
        if (exp_blk_q.size() == 0) begin
          chk("extra_en", 512'(core_en), 512'(1'b0));
        end else begin
          chk("blk", core_data, exp_blk_q.pop_front());
          chk("init", 512'(core_init), 512'(exp_init_q.pop_front()));
        end
        chk("busy", 512'(busy), 512'(1'b1));
        pending  = 1'b1;
        cnt      = fin_delay;
        cur_blk  = core_data;
        stab_bad = 1'b0;
      end
      if (digest_valid) begin
        dv_cnt++;
        if (exp_dig_q.size() == 0) chk("extra_dv", 512'(digest_valid), 512'(1'b0));
        else chk("digest", 512'(digest), 512'(exp_dig_q.pop_front()));
        chk("dv_lat", 512'(cyc - fin_cyc), 512'(1));
        chk("busy_done", 512'(busy), 512'(1'b0));
        chk("blk_left", 512'(exp_blk_q.size()), 512'(0));
      end
    end
  end

  initial begin
    bit hit;
    int lens [6] = '{7, 8, 55, 56, 63, 120};
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = 4'd0;
    core_fin = 1'b0; core_odata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 512'(in_ready), 512'(1'b1));

    send_msg(0);
    wait_done();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    wait_done();
    for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
    send_msg(64);
    wait_done();
    send_msg(72);
    wait_done();
    fin_delay = 20;
    send_msg(128);
    wait_done();
    foreach (lens[i]) begin
      fin_delay = int'($urandom_range(1, 5));
      send_msg(lens[i]);
      wait_done();
    end

    // Reset while block 1 of "abc" is in the core
    fin_delay = 20;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk);
      hit = pending;
    end
    chk("rst_wait_seen", 512'(hit), 512'(1'b1));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    pending = 1'b0;
    core_fin = 1'b0;
    exp_blk_q.delete();
    exp_init_q.delete();
    exp_dig_q.delete();
    chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst2", 512'(in_ready), 512'(1'b1));
    fin_delay = 3;
    send_msg(3);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jh_msg_ctrl.md
Name: jh_msg_ctrl

Overview:
Message-level controller for the JH compression core.
- Accepts a byte-aligned message as a stream of 64-bit words with valid/ready.
- Assembles 512-bit blocks and applies JH padding: a '1' bit, zeros, then the 128-bit big-endian bit length.
- Sequences the core's init/enable/done handshake and captures the digest from the final block's output.
- Sits between the host/bus interface and the JH core. It is the only driver of the core's control inputs.

Parameters:
- OUT_BITS, 256, digest width delivered. Legal values: 224, 256, 384, 512. The low OUT_BITS of the core output are taken.
- LEN_BITS, 64, width of the internal bit-length counter. It is zero-extended to 128 bits in the length field.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts the word this cycle
- in_data  in  64  message word; first byte in bits [63:56]
- in_last  in  1  final word of message
- in_bytes  in  4  valid bytes in the last word, 1..8. 0 is legal only on the first word, and means an empty message. Ignored unless in_last.
- core_en  out  1  one-cycle pulse that starts compression of core_data
- core_init  out  1  asserted with core_en for the first block of a message (loads the IV)
- core_data  out  512  block presented to the core; held stable from core_en until core_fin
- core_fin  in  1  one-cycle pulse: block compression done
- core_odata  in  512  core chaining output, valid in the cycle core_fin is high
- digest  out  OUT_BITS  hash result
- digest_valid  out  1  one-cycle pulse; digest is held until the next message completes
- busy  out  1  high from the first accepted word until digest_valid

Behaviour:
Reset (rst_n=0 at a clk edge):
- State goes to IDLE.
- in_ready, core_en, core_init, digest_valid, busy reset to 0. in_ready rises to 1 in the first cycle after reset.
- core_data, digest, the length counter and the word counter all reset to 0.
- Reset mid-message discards all progress; the core shares rst_n.

FSM states: IDLE, FILL, ISSUE, WAIT, PADBLK, DONE.

IDLE:
- in_ready=1.
- A handshake (in_valid&in_ready) enters FILL with the word stored. first_blk=1.

FILL:
- in_ready=1. Each handshake writes the word into lane wcnt (lane 0 = bits [511:448]). wcnt increments mod 8.
- Length counter adds 64 per full word, or 8*in_bytes on the last word.
- A full block (8 words, no last) goes to ISSUE.
- in_last goes to ISSUE with pad_pending set.
- On in_last, the valid bytes are kept. The next bit is set to 1 if the message is non-empty and the last word ends short of the block end. All remaining bits are cleared.

Boundary cases for the last word:
- Message length a multiple of 512 (last word has 8 bytes in lane 7): no '1' bit in this block. The final pad block starts with 0x80.
- Last word with 8 bytes in lanes 0..6: the '1' goes in the first bit of the next lane, and the remaining lanes are cleared.
- Empty message: no data block is issued. Go directly to PADBLK with one_in_pad=1.

ISSUE (1 cycle):
- core_en=1, core_init=first_blk, in_ready=0. Then first_blk clears and the FSM enters WAIT.

WAIT:
- in_ready=0 (single block buffer; no overlap).
- On core_fin:
  - if pad_pending: go to PADBLK;
  - else if final: go to DONE;
  - else: clear the block buffer, wcnt=0, go to FILL.

PADBLK (1 cycle):
- core_data = {one_in_pad ? 8'h80 : 8'h00, 376 zero bits, 128-bit length}.
- one_in_pad is 1 when the data block carried no '1' bit (length multiple of 512, or empty message).
- Set final, clear pad_pending, go to ISSUE.
- Every message ends with exactly one PADBLK block, because JH padding always adds 512 + (-l mod 512) bits.

DONE (1 cycle):
- digest = core_odata[OUT_BITS-1:0], captured on the final core_fin.
- digest_valid=1, busy=0, return to IDLE.

Timing and rules:
- Latency from the last-word handshake to digest_valid = 2×(1 + core latency) + 2 cycles.
- core_fin outside WAIT is ignored.
- in_valid without in_ready leaves state unchanged. in_data may change while in_ready is low.
- The length counter saturates at 2^LEN_BITS−1 (not checked by the bench).

Decomposition:
- Shared package jh_pkg:
  - state enum;
  - BLK_W=512, WORD_W=64, LEN_FIELD_W=128;
  - PAD_BYTE=8'h80.
- One natural sub-module: jh_pad_mask. It is combinational and takes in_bytes, wcnt and the non-empty flag. It produces the 512-bit keep-mask and the '1'-bit position for the last data block.

Test Plan:
- Empty message (one word, in_last, in_bytes=0):
  - exactly one core_en with core_init=1;
  - core_data = 0x80 followed by zeros, length field 0;
  - digest_valid one cycle after core_fin.
- "abc" (in_data=0x6162630000000000, in_last, in_bytes=3), two blocks:
  - block 1 = 0x61626380 then zeros, init=1;
  - block 2 = all zero except length=0x18, init=0.
- 64-byte message (8 full words, last on word 8):
  - block 1 = data, init=1;
  - block 2 = 0x80, zeros, length=0x200.
- 72-byte message, 9th word in_bytes=8:
  - block 2 = word 9 in lane 0, 0x80 at bits [447:440], zeros;
  - block 3 = zeros with length=0x240; three core_en total.
- Backpressure: hold in_valid=1 for 16 words with the core stub fin delayed 20 cycles.
  - in_ready is low from ISSUE through core_fin;
  - no word is lost or duplicated;
  - core_data is stable for the full WAIT period.
- Reset asserted during WAIT of block 1, then a new "abc" message:
  - outputs return to their reset values the cycle after the reset edge;
  - the second message produces the same two blocks as the "abc" test, and block 1 has core_init=1.
